// File: rtl/dip_debounce.sv
`default_nettype none
// ============================================================================
// Module  : dip_debounce
// Brief   : 4-bit DIP debouncer: 2-flop sync, tap-edge strobe, settle FSM.
//           Optional chg pulse flop enabled by macro DIP_DEBOUNCE_CHG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module dip_debounce #(
  parameter int NTAPS        = 6,
  parameter int TAP_SEL      = 0,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NTAPS-1:0] taps,
  input  logic [3:0]       dip_raw,
  output logic [3:0]       val,
  output logic             chg,
  output logic             busy
);

  localparam logic [3:0] c_stable_ticks = 4'(STABLE_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic       r_tap_prev;
  logic [3:0] r_cand;
  logic [3:0] r_cnt;
  logic [3:0] r_val;
  logic       r_busy;
  logic [3:0] w_cand_nxt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] w_cnt_inc;
  logic [3:0] w_val_nxt;
  logic       w_strobe;
  logic       w_unused_taps;

  // Only TAP_SEL is consumed; the remaining taps belong to other blocks.
  assign w_unused_taps = ^taps;
  assign w_strobe      = taps[TAP_SEL] & ~r_tap_prev;
  assign w_cnt_inc     = r_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 4'd0;
      r_sync2    <= 4'd0;
      r_tap_prev <= 1'b0;
      r_state    <= IDLE;
      r_cand     <= 4'd0;
      r_cnt      <= 4'd0;
      r_val      <= 4'd0;
      r_busy     <= 1'b0;
    end else begin
      r_sync1    <= dip_raw;
      r_sync2    <= r_sync1;
      r_tap_prev <= taps[TAP_SEL];
      r_state    <= w_next;
      r_cand     <= w_cand_nxt;
      r_cnt      <= w_cnt_nxt;
      r_val      <= w_val_nxt;
      r_busy     <= (w_next == SETTLE);
    end
  end

  // Reload takes priority over counting, so a strobe coincident with a new
  // candidate is never credited to it.
  always_comb begin
    w_next     = r_state;
    w_cand_nxt = r_cand;
    w_cnt_nxt  = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_sync2 != r_val) begin
          w_cand_nxt = r_sync2;
          w_cnt_nxt  = 4'd0;
          w_next     = SETTLE;
        end
      end
      SETTLE: begin
        if (r_sync2 == r_val) begin
          w_next = IDLE;
        end else if (r_sync2 != r_cand) begin
          w_cand_nxt = r_sync2;
          w_cnt_nxt  = 4'd0;
        end else if (w_strobe) begin
          if (r_cnt != 4'hF) w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == c_stable_ticks) w_next = COMMIT;
        end
      end
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Registered outputs load on entry so they are visible during COMMIT.
    w_val_nxt = (w_next == COMMIT) ? w_cand_nxt : r_val;
  end

`ifdef DIP_DEBOUNCE_CHG_EN
  logic r_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_chg <= 1'b0;
    else        r_chg <= (w_next == COMMIT);
  end

  assign chg = r_chg;
`else
  assign chg = 1'b0;
`endif

  assign val  = r_val;
  assign busy = r_busy;

endmodule
`default_nettype wire
